// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_pkg
// Purpose  : Shared types and helpers for the sequential shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of an iteration counter that can hold the value WIDTH
    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Purpose  : Control FSM for seq_multiplier. Owns the iteration counter and
//            the handshake outputs, and strobes the datapath with
//            load / step / finish.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    input  logic out_ready_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output logic load_o,
    output logic step_o,
    output logic finish_o
);

    localparam int CNT_W = calc_cnt_w(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_iter;

    assign last_iter = (cnt_q == CNT_W'(1));

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs from the state register; strobes for the datapath
    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_DONE);
        load_o      = (state_q == ST_IDLE) && in_valid_i;
        step_o      = (state_q == ST_BUSY);
        finish_o    = (state_q == ST_BUSY) && last_iter;
    end

endmodule : seq_mult_ctrl
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Sequential shift-add multiplier, one multiplier bit per clock,
//            valid/ready handshake on operands and product.
//            Optional two's-complement mode when SEQ_MULT_SIGNED_EN is
//            defined (adds the signed_op port).
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_op,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c
);

    logic               load, step, finish;

    // Datapath state: multiplicand, {accumulator, multiplier} shift register
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] c_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_shift;
    logic [2*WIDTH-1:0] product;

    seq_mult_ctrl #(
        .WIDTH       (WIDTH)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .load_o      (load),
        .step_o      (step),
        .finish_o    (finish)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;
    logic neg_d;

    // Signed operands are reduced to magnitudes at accept; the most-negative
    // value maps to 2**(WIDTH-1), which still fits as an unsigned WIDTH-bit value
    assign a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign neg_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);

    // Sign of the result, remembered from the accept edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= neg_d;
        end
    end

    assign product = neg_q ? (~acc_shift + 1'b1) : acc_shift;
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign product = acc_shift;
`endif

    // One shift-add iteration: conditional add into the upper half keeps the
    // carry in bit WIDTH, which then shifts down into the product
    assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign acc_shift = {sum, acc_q[WIDTH-1:1]};

    // Operand latch, iteration shift register and registered product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            c_q     <= '0;
        end else begin
            if (load) begin
                mcand_q <= a_mag;
                acc_q   <= {{WIDTH{1'b0}}, b_mag};
            end else if (step) begin
                acc_q   <= acc_shift;
            end
            if (finish) begin
                c_q <= product;
            end
        end
    end

    assign c = c_q;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Self-checking bench for seq_multiplier (WIDTH=4), directed cases
//            plus randomized operations against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           signed_op = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (signed_op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    // Compare and count
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference product from plain integer arithmetic
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sg);
        int p;
        if (sg) p = int'($signed(x)) * int'($signed(y));
        else    p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    // One full transaction: accept, latency, result, optional backpressure, return to IDLE
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic sg, input int hold, input logic [2*W-1:0] exp);
        int n;
        int lat;
        logic [2*W-1:0] c_held;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready_idle"}, in_ready, 1'b1);
        a         = ta;
        b         = tb;
        signed_op = sg;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        signed_op = 1'($urandom);
        check({tag, "_in_ready_fall"}, in_ready, 1'b0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, lat, W);
        check({tag, "_c"}, c, exp);
        c_held = c;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_bp_valid"}, out_valid, 1'b1);
            check({tag, "_bp_c"}, c, c_held);
            check({tag, "_bp_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ret_valid"}, out_valid, 1'b0);
        check({tag, "_ret_in_ready"}, in_ready, 1'b1);
        check({tag, "_ret_c"}, c, exp);
    endtask

    initial begin
        logic [W-1:0] opa [0:13];
        logic [W-1:0] opb [0:13];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_c", c, 8'h00);
        rst_n = 1'b1;

        // Basic products
        run_op("p2x3",   4'd2,  4'd3,  1'b0, 0, 8'd6);
        run_op("p5x9",   4'd5,  4'd9,  1'b0, 0, 8'h2D);
        run_op("p15x15", 4'd15, 4'd15, 1'b0, 0, 8'hE1);
        run_op("p0x13",  4'd0,  4'd13, 1'b0, 0, 8'h00);
        run_op("pDx5",   4'hD,  4'd5,  1'b0, 0, 8'h41);

        // Backpressure for 5 cycles
        run_op("bp6x7",  4'd6,  4'd7,  1'b0, 5, 8'd42);

        // Back-to-back: in_valid high with fresh operands every cycle
        for (int k = 0; k < 14; k++) begin
            opa[k] = W'($urandom);
            opb[k] = W'($urandom);
        end
        opa[0] = 4'd3; opb[0] = 4'd4;
        opa[6] = 4'd1; opb[6] = 4'd1;
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            in_valid  = (k <= 10);
            a         = opa[k];
            b         = opb[k];
            signed_op = 1'b0;
            @(posedge clk);
            #1;
            if (k == 4) begin
                check("b2b_first_valid", out_valid, 1'b1);
                check("b2b_first_c", c, 8'd12);
            end
            if (k == 5) check("b2b_idle_gap", in_ready, 1'b1);
            if (k == 6) check("b2b_second_busy", in_ready, 1'b0);
            if (k == 8) check("b2b_c_hold", c, 8'd12);
            if (k == 10) begin
                check("b2b_second_valid", out_valid, 1'b1);
                check("b2b_second_c", c, 8'd1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_end_idle", in_ready, 1'b1);

        // Reset in the middle of an operation
        @(negedge clk);
        a = 4'd7; b = 4'd7; signed_op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstbusy_out_valid", out_valid, 1'b0);
        check("rstbusy_c", c, 8'h00);
        check("rstbusy_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("p2x2", 4'd2, 4'd2, 1'b0, 0, 8'd4);

`ifdef SEQ_MULT_SIGNED_EN
        run_op("s_m3x5",  4'hD, 4'd5, 1'b1, 0, 8'hF1);
        run_op("s_m8xm8", 4'h8, 4'h8, 1'b1, 0, 8'h40);
        run_op("s_7xm1",  4'd7, 4'hF, 1'b1, 0, 8'hF9);
        run_op("s_off",   4'hD, 4'd5, 1'b0, 0, 8'h41);
`endif

        // Randomized operations
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op("rand", ra, rb, rs, $urandom_range(0, 3), ref_mul(ra, rb, rs));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_multiplier
`default_nettype wire

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier, the successor to the team's 4x4 combinational `multiplier`. It takes two WIDTH-bit operands through a valid/ready handshake and computes the 2*WIDTH-bit product at one bit per clock. It returns the result through a second valid/ready handshake. It sits on datapaths where area matters more than latency, and is drop-in compatible in operand and product naming (`a`, `b`, `c`).

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2..32.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: operands `a`/`b` present.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: multiplicand.
- `b` input WIDTH: multiplier.
- `signed_op` input 1: present only with `SEQ_MULT_SIGNED_EN`; 1 means two's-complement operation; sampled at accept.
- `out_valid` output 1: `c` holds a completed product.
- `out_ready` input 1: consumer takes `c`.
- `c` output 2*WIDTH: product.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready` at an edge:
  - latch `a`/`b` (and `signed_op`);
  - clear accumulator;
  - load counter with WIDTH;
  - go to BUSY.
- **BUSY:** each edge:
  - if multiplier LSB=1, add multiplicand to the upper accumulator half;
  - shift right one;
  - decrement counter.
  - Counter reaching 0 on this edge: the final product is written to `c`, go to DONE.
- **DONE:** `out_valid`=1. On `out_valid`&&`out_ready`, go to IDLE.
- `c` holds its value until the next product is written.
- `in_ready`=1 only in IDLE. No accept in DONE, even while the output handshake completes; minimum issue interval is WIDTH+2 cycles.
- Operand inputs are ignored outside the accept edge. Changes during BUSY or DONE have no effect.
- Arithmetic:
  - The product is exact; no truncation or overflow is possible in 2*WIDTH bits.
  - Accumulator is WIDTH+1 bits wide on the add to keep the carry.
- Reset (`rst_n`=0 at an edge, any state) gives:
  - state=IDLE;
  - `in_ready`=1, `out_valid`=0, `c`=0;
  - counter and accumulator cleared.
- An in-flight operation is discarded, with no partial result.

## Timing
- Accept edge is E0. Iteration edges are E1..E_WIDTH.
- `out_valid` rises after edge E_WIDTH, i.e. WIDTH cycles after accept.
- `in_ready` falls after E0.
- Latency is identical for signed and unsigned.
- `out_valid` and `c` are registered. `in_ready` is decoded from the state register only, with no combinational path from `in_valid`/`out_ready`.
- `out_ready` held low: DONE persists indefinitely with `c` stable.
- `out_ready` already high on entry to DONE: handshake completes on the first DONE edge, and `in_ready` is 1 in the following cycle.

## Configuration
- Macro: `SEQ_MULT_SIGNED_EN`.
- **Defined:**
  - `signed_op` port exists.
  - With `signed_op`=1 at accept, operand magnitudes are taken at accept and multiplied unsigned.
  - The product is negated on the final BUSY edge when operand signs differ.
  - Result is the exact two's-complement 2*WIDTH-bit product. The most-negative × most-negative case fits.
  - With `signed_op`=0, behaviour is unsigned.
- **Undefined:** no `signed_op` port, no sign logic; always unsigned.

## Structure
- Package `seq_mult_pkg` holds:
  - state enum (IDLE/BUSY/DONE);
  - `CNT_W = $clog2(WIDTH+1)` helper function.
- One natural sub-module, `seq_mult_ctrl`: FSM, counter, and handshake outputs, driving load/step/finish strobes.
- Datapath registers (multiplicand, accumulator/multiplier shift register, sign flag) stay in the top.

## Test plan
All scenarios use WIDTH=4.
- **Basic products:** `a`=2, `b`=3 accepted with `out_ready`=1 -> `out_valid` exactly 4 cycles after accept, `c`=6. Same for 5×9 -> `c`=45 (0x2D). 15×15 -> `c`=225 (0xE1). 0×13 -> `c`=0.
- **Back-to-back and ignored operands:** `in_valid` held high with new operands every cycle -> only operands present at IDLE accept edges are used, every WIDTH+2 cycles. Results 3×4=12, then 1×1=1, in order.
- **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid` -> `c` and `out_valid` stable; `in_ready`=0 throughout. `out_ready`=1 -> IDLE next cycle.
- **Reset during BUSY:** `rst_n`=0 on cycle 2 of a 7×7 operation -> next cycle `out_valid`=0, `c`=0, `in_ready`=1. A fresh 2×2 -> `c`=4.
- **Signed mode (`SEQ_MULT_SIGNED_EN` defined):** `signed_op`=1:
  - −3×5 -> `c`=0xF1;
  - −8×−8 -> `c`=0x40;
  - 7×−1 -> `c`=0xF9.
  - With `signed_op`=0, 13×5 -> `c`=0x41.
- **Macro undefined:** `a`=4'hD, `b`=5 -> `c`=0x41. Latency is 4 cycles in all modes.
